// File: rtl/sys_trap_ctrl.sv
// +-------------------------------------------------------------------------+
// | sys_trap_ctrl: machine-mode trap/interrupt sequencer and trap CSRs.       |
// | Optional timer compare (mtime/mtimecmp) enabled by TRAP_TIMER_EN.         |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module sys_trap_ctrl #(
  parameter int               DRAIN_MAX = 15,
  parameter logic [`XLEN-1:0] MTVEC_RST = 'h200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_irq,
  input  logic             sw_irq,
  input  logic [1:0]       dmem_exception,
  input  logic [`XLEN-1:0] exc_pc,
  input  logic             ecall_vld,
  input  logic [`XLEN-1:0] ecall_pc,
  input  logic             mret_vld,
  input  logic [`XLEN-1:0] int_pc,
  input  logic             mem_busy,
`ifdef TRAP_TIMER_EN
  input  logic [63:0]      mtime,
`endif
  input  logic             csr_vld,
  input  logic [11:0]      csr_addr,
  input  logic [`XLEN-1:0] csr_wdata,
  output logic [`XLEN-1:0] csr_rdata,
  output logic             fetch_hold,
  output logic             trap_vld,
  output logic [`XLEN-1:0] trap_pc
);

  localparam int XL = `XLEN;
  localparam int CW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);
  localparam logic [XL-1:0] CAUSE_INT   = {1'b1, {(XL-1){1'b0}}};
  localparam logic [XL-1:0] CAUSE_LOAD  = XL'(5);
  localparam logic [XL-1:0] CAUSE_STORE = XL'(7);
  localparam logic [XL-1:0] CAUSE_ECALL = XL'(11);
  localparam logic [XL-1:0] CAUSE_SW    = CAUSE_INT | XL'(3);
  localparam logic [XL-1:0] CAUSE_TMR   = CAUSE_INT | XL'(7);
  localparam logic [XL-1:0] CAUSE_EXT   = CAUSE_INT | XL'(11);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_TRAP, ST_RET} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XL-1:0]   cause_q, cause_d;
  logic [XL-1:0]   epc_q, epc_d;
  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic [2:0]      mie_q, mie_d;      // {MEIE, MTIE, MSIE}
  logic [XL-1:2]   mtvec_q, mtvec_d;
  logic [XL-1:0]   mepc_q, mepc_d;
  logic [XL-1:0]   mcause_q, mcause_d;
  logic            mtip;
  logic [2:0]      mip_v;
  logic [2:0]      irq_act;

`ifdef TRAP_TIMER_EN
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  assign mtip = (mtime >= mtimecmp_q);
`else
  assign mtip = 1'b0;
`endif

  assign mip_v   = {ext_irq, mtip, sw_irq};
  assign irq_act = mie_q & mip_v;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    cause_d    = cause_q;
    epc_d      = epc_q;
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef TRAP_TIMER_EN
    mtimecmp_d = mtimecmp_q;
`endif

    // Software writes first so the trap/ret updates below override them.
    if (csr_vld) begin
      case (csr_addr)
        12'h300: begin
          mst_mie_d  = csr_wdata[3];
          mst_mpie_d = csr_wdata[7];
        end
        12'h304: mie_d    = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
        12'h305: mtvec_d  = csr_wdata[XL-1:2];
        12'h341: mepc_d   = csr_wdata;
        12'h342: mcause_d = csr_wdata;
`ifdef TRAP_TIMER_EN
        12'h7C0: mtimecmp_d[31:0]  = csr_wdata[31:0];
        12'h7C1: mtimecmp_d[63:32] = csr_wdata[31:0];
`endif
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (|dmem_exception) begin
          epc_d   = exc_pc;
          cause_d = dmem_exception[0] ? CAUSE_LOAD : CAUSE_STORE;
          state_d = ST_DRAIN;
        end else if (ecall_vld) begin
          epc_d   = ecall_pc;
          cause_d = CAUSE_ECALL;
          state_d = ST_DRAIN;
        end else if (mret_vld) begin
          state_d = ST_RET;
        end else if (mst_mie_q && (|irq_act)) begin
          cause_d = irq_act[2] ? CAUSE_EXT : (irq_act[0] ? CAUSE_SW : CAUSE_TMR);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        // A synchronous fault outranks an interrupt that is still draining.
        if (cause_q[XL-1] && (|dmem_exception)) begin
          epc_d   = exc_pc;
          cause_d = dmem_exception[0] ? CAUSE_LOAD : CAUSE_STORE;
        end
        if (!mem_busy || (cnt_q == CW'(DRAIN_MAX))) begin
          state_d = ST_TRAP;
        end
      end
      ST_TRAP: begin
        mepc_d     = cause_q[XL-1] ? int_pc : epc_q;
        mcause_d   = cause_q;
        mst_mpie_d = mst_mie_q;
        mst_mie_d  = 1'b0;
        state_d    = ST_IDLE;
      end
      ST_RET: begin
        mst_mie_d  = mst_mpie_q;
        mst_mpie_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: begin
        csr_rdata[3] = mst_mie_q;
        csr_rdata[7] = mst_mpie_q;
      end
      12'h304: begin
        csr_rdata[3]  = mie_q[0];
        csr_rdata[7]  = mie_q[1];
        csr_rdata[11] = mie_q[2];
      end
      12'h344: begin
        csr_rdata[3]  = mip_v[0];
        csr_rdata[7]  = mip_v[1];
        csr_rdata[11] = mip_v[2];
      end
      12'h305: csr_rdata = {mtvec_q, 2'b00};
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
`ifdef TRAP_TIMER_EN
      12'h7C0: csr_rdata = XL'(mtimecmp_q[31:0]);
      12'h7C1: csr_rdata = XL'(mtimecmp_q[63:32]);
`endif
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    fetch_hold = (state_q != ST_IDLE);
    trap_vld   = (state_q == ST_TRAP) || (state_q == ST_RET);
    trap_pc    = '0;
    if (state_q == ST_TRAP) begin
      trap_pc = {mtvec_q, 2'b00};
    end else if (state_q == ST_RET) begin
      trap_pc = mepc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST[XL-1:2];
      mepc_q     <= '0;
      mcause_q   <= '0;
`ifdef TRAP_TIMER_EN
      mtimecmp_q <= '1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
`ifdef TRAP_TIMER_EN
      mtimecmp_q <= mtimecmp_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sys_trap_ctrl.sv
// +-------------------------------------------------------------------------+
// | tb_sys_trap_ctrl: directed scoreboard bench for sys_trap_ctrl.            |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module tb_sys_trap_ctrl;

  localparam int DRAIN_MAX = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ext_irq = 1'b0;
  logic             sw_irq = 1'b0;
  logic [1:0]       dmem_exception = '0;
  logic [`XLEN-1:0] exc_pc = '0;
  logic             ecall_vld = 1'b0;
  logic [`XLEN-1:0] ecall_pc = '0;
  logic             mret_vld = 1'b0;
  logic [`XLEN-1:0] int_pc = '0;
  logic             mem_busy = 1'b0;
`ifdef TRAP_TIMER_EN
  logic [63:0]      mtime = '0;
`endif
  logic             csr_vld = 1'b0;
  logic [11:0]      csr_addr = '0;
  logic [`XLEN-1:0] csr_wdata = '0;
  logic [`XLEN-1:0] csr_rdata;
  logic             fetch_hold;
  logic             trap_vld;
  logic [`XLEN-1:0] trap_pc;

  sys_trap_ctrl #(.DRAIN_MAX(DRAIN_MAX), .MTVEC_RST('h200)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .sw_irq(sw_irq),
    .dmem_exception(dmem_exception), .exc_pc(exc_pc),
    .ecall_vld(ecall_vld), .ecall_pc(ecall_pc), .mret_vld(mret_vld),
    .int_pc(int_pc), .mem_busy(mem_busy),
`ifdef TRAP_TIMER_EN
    .mtime(mtime),
`endif
    .csr_vld(csr_vld), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .fetch_hold(fetch_hold),
    .trap_vld(trap_vld), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; int lo; int hi; } trap_t;
  typedef struct { int sel; logic [31:0] exp; string nm; } rd_t;

  trap_t trap_q[$];
  rd_t   rd_q[$];
  logic  rd_stb = 1'b0;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every redirect and every read strobe consumes one expectation.
  always @(negedge clk) begin
    if (trap_vld) begin
      n_cmp++;
      if (trap_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_trap: got trap_pc=%h at cycle %0d, required no trap", trap_pc, cyc);
      end else begin
        trap_t e;
        e = trap_q.pop_front();
        if (trap_pc !== e.pc || cyc < e.lo || cyc > e.hi) begin
          n_bad++;
          $display("FAIL trap: got pc=%h cycle=%0d, required pc=%h cycle %0d..%0d",
                   trap_pc, cyc, e.pc, e.lo, e.hi);
        end
      end
    end
    if (rd_stb && rd_q.size() != 0) begin
      rd_t r;
      logic [31:0] act;
      r = rd_q.pop_front();
      case (r.sel)
        1:       act = {31'b0, fetch_hold};
        2:       act = {31'b0, trap_vld};
        default: act = csr_rdata[31:0];
      endcase
      n_cmp++;
      if (act !== r.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", r.nm, act, r.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_vld = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_vld = 1'b0;
  endtask

  task automatic chk(input int sel, input logic [11:0] a, input logic [31:0] exp, input string nm);
    rd_t r;
    csr_addr = a;
    r.sel = sel; r.exp = exp; r.nm = nm;
    rd_q.push_back(r);
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
  endtask

  task automatic exp_trap(input logic [31:0] pc, input int lo, input int hi);
    trap_t t;
    t.pc = pc; t.lo = lo; t.hi = hi;
    trap_q.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk(0, 12'h305, 32'h200, "rst_mtvec");
    chk(0, 12'h300, 32'h0,   "rst_mstatus");
    chk(1, 12'h000, 32'h0,   "rst_fetch_hold");
    chk(2, 12'h000, 32'h0,   "rst_trap_vld");
    chk(0, 12'h341, 32'h0,   "rst_mepc");
    chk(0, 12'h342, 32'h0,   "rst_mcause");
    chk(0, 12'h123, 32'h0,   "unowned_addr");
    ext_irq = 1'b1; sw_irq = 1'b1;
    chk(0, 12'h344, 32'h808, "mip_read");
    ext_irq = 1'b0; sw_irq = 1'b0;

    // Load fault, mem idle: redirect two cycles later
    wr(12'h305, 32'h400);
    wr(12'h300, 32'h8);
    dmem_exception = 2'b01; exc_pc = 32'h1234; n = cyc;
    exp_trap(32'h400, n + 2, n + 2);
    tick();
    dmem_exception = 2'b00;
    chk(1, 12'h000, 32'h1, "hold_in_drain");
    repeat (2) tick();
    chk(0, 12'h341, 32'h1234, "load_mepc");
    chk(0, 12'h342, 32'h5,    "load_mcause");
    chk(0, 12'h300, 32'h80,   "load_mstatus");

    // Store fault; mtvec low bits are masked
    wr(12'h305, 32'h403);
    chk(0, 12'h305, 32'h400, "mtvec_mask");
    dmem_exception = 2'b10; exc_pc = 32'h2000; n = cyc;
    exp_trap(32'h400, n + 2, n + 2);
    tick();
    dmem_exception = 2'b00;
    repeat (3) tick();
    chk(0, 12'h342, 32'h7, "store_mcause");
    chk(0, 12'h300, 32'h0, "store_mstatus");

    // Both fault bits: load wins
    dmem_exception = 2'b11; exc_pc = 32'h2100; n = cyc;
    exp_trap(32'h400, n + 2, n + 2);
    tick();
    dmem_exception = 2'b00;
    repeat (3) tick();
    chk(0, 12'h342, 32'h5, "both_mcause");

    // External interrupt with mem_busy stuck high: forced after DRAIN_MAX
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h800);
    int_pc = 32'h5550; ext_irq = 1'b1; mem_busy = 1'b1; n = cyc;
    exp_trap(32'h400, n + 3, n + 2 + DRAIN_MAX);
    repeat (30) tick();
    mem_busy = 1'b0; ext_irq = 1'b0;
    chk(0, 12'h342, 32'h8000000B, "ext_mcause");
    chk(0, 12'h341, 32'h5550,     "ext_mepc");
    chk(0, 12'h300, 32'h80,       "ext_mstatus");

    // mret: redirect to mepc the next cycle
    mret_vld = 1'b1; n = cyc;
    exp_trap(32'h5550, n + 1, n + 1);
    tick();
    mret_vld = 1'b0;
    tick();
    chk(0, 12'h300, 32'h88, "mret_mstatus");

    // ecall beats a simultaneous interrupt
    ecall_vld = 1'b1; ecall_pc = 32'h7770; ext_irq = 1'b1; n = cyc;
    exp_trap(32'h400, n + 2, n + 2);
    tick();
    ecall_vld = 1'b0; ext_irq = 1'b0;
    repeat (2) tick();
    chk(0, 12'h342, 32'hB,    "ecall_mcause");
    chk(0, 12'h341, 32'h7770, "ecall_mepc");

    // Fault during an interrupt drain replaces the interrupt cause
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h8);
    sw_irq = 1'b1; mem_busy = 1'b1; n = cyc;
    tick();
    sw_irq = 1'b0; dmem_exception = 2'b10; exc_pc = 32'h9990;
    tick();
    dmem_exception = 2'b00; mem_busy = 1'b0;
    exp_trap(32'h400, n + 3, n + 3);
    repeat (2) tick();
    chk(0, 12'h342, 32'h7,    "replace_mcause");
    chk(0, 12'h341, 32'h9990, "replace_mepc");

    // CSR write in the TRAP cycle loses to the trap update
    wr(12'h300, 32'h8);
    ecall_vld = 1'b1; ecall_pc = 32'hABC0; n = cyc;
    exp_trap(32'h400, n + 2, n + 2);
    tick();
    ecall_vld = 1'b0;
    tick();
    wr(12'h342, 32'h55);
    chk(0, 12'h342, 32'hB,  "trap_vs_csr_mcause");
    chk(0, 12'h300, 32'h80, "trap_mstatus");

    // CSR write in the RET cycle loses to the ret update
    mret_vld = 1'b1; n = cyc;
    exp_trap(32'hABC0, n + 1, n + 1);
    tick();
    mret_vld = 1'b0;
    wr(12'h300, 32'h0);
    chk(0, 12'h300, 32'h88, "ret_vs_csr_mstatus");

    // Reset during DRAIN discards the pending trap
    sw_irq = 1'b1; mem_busy = 1'b1;
    tick();
    sw_irq = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk(1, 12'h000, 32'h0, "rst_mid_fetch_hold");
    chk(2, 12'h000, 32'h0, "rst_mid_trap_vld");
    rst = 1'b0; mem_busy = 1'b0;
    repeat (4) tick();
    chk(0, 12'h305, 32'h200, "rst_mid_mtvec");
    chk(0, 12'h300, 32'h0,   "rst_mid_mstatus");

`ifdef TRAP_TIMER_EN
    chk(0, 12'h7C0, 32'hFFFFFFFF, "mtimecmp_rst");
    mtime = 64'd99;
    wr(12'h7C0, 32'd100);
    wr(12'h7C1, 32'd0);
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    chk(0, 12'h344, 32'h0, "mip_below_cmp");
    int_pc = 32'h6660; mtime = 64'd100; n = cyc;
    exp_trap(32'h200, n + 2, n + 2);
    chk(0, 12'h344, 32'h80, "mip_at_cmp");
    repeat (3) tick();
    chk(0, 12'h342, 32'h80000007, "timer_mcause");
    chk(0, 12'h341, 32'h6660,     "timer_mepc");
`else
    wr(12'h7C0, 32'd100);
    chk(0, 12'h7C0, 32'h0, "no_timer_7c0");
    chk(0, 12'h7C1, 32'h0, "no_timer_7c1");
`endif

    repeat (5) tick();
    n_cmp++;
    if (trap_q.size() != 0) begin
      n_bad++;
      $display("FAIL trap_missing: got %0d outstanding, required 0", trap_q.size());
    end
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL read_missing: got %0d outstanding, required 0", rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
